// File: rtl/munoc_response_packetizer.sv
// Turns AXI B/R responses into NoC packets of 34-bit flits {head, tail, payload}.
// B -> one head+tail flit; R -> header flit followed by BW_DATA/32 data flits.
module munoc_response_packetizer #(
  parameter int BW_DATA    = 64,
  parameter int BW_TID     = 4,
  parameter int BW_NODE_ID = 4
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [BW_NODE_ID-1:0] b_node_id,
  input  logic [BW_TID-1:0]     b_tid,
  input  logic [1:0]            b_resp,
  input  logic                  r_valid,
  output logic                  r_ready,
  input  logic [BW_NODE_ID-1:0] r_node_id,
  input  logic [BW_TID-1:0]     r_tid,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  input  logic [BW_DATA-1:0]    r_data,
  output logic                  link_valid,
  input  logic                  link_ready,
  output logic [33:0]           link_flit
);

  localparam int BEATS = BW_DATA / 32;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ZB_B  = 32 - 4 - BW_NODE_ID - BW_TID;
  localparam int ZB_R  = ZB_B - 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, SEND_B, SEND_RH, SEND_RD} state_e;

  state_e                 state_q, state_d;
  logic                   prio_r_q, prio_r_d;
  logic [CW-1:0]          beat_q, beat_d;
  logic [BW_NODE_ID-1:0]  b_node_q, b_node_d, r_node_q, r_node_d;
  logic [BW_TID-1:0]      b_tid_q, b_tid_d, r_tid_q, r_tid_d;
  logic [1:0]             b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic                   r_last_q, r_last_d;
  logic [BW_DATA-1:0]     r_data_q, r_data_d;

  logic [BEATS-1:0][31:0] r_words;
  logic [31:0]            b_pl, r_pl, payload;
  logic                   head, tail, grant_r, grant_b;

  assign r_words   = r_data_q;
  assign b_pl      = {2'b01, b_node_q, b_tid_q, b_resp_q, {ZB_B{1'b0}}};
  assign r_pl      = {2'b10, r_node_q, r_tid_q, r_resp_q, r_last_q, {ZB_R{1'b0}}};
  assign link_flit = {head, tail, payload};

  always_comb begin
    state_d    = state_q;
    prio_r_d   = prio_r_q;
    beat_d     = beat_q;
    b_node_d   = b_node_q;
    b_tid_d    = b_tid_q;
    b_resp_d   = b_resp_q;
    r_node_d   = r_node_q;
    r_tid_d    = r_tid_q;
    r_resp_d   = r_resp_q;
    r_last_d   = r_last_q;
    r_data_d   = r_data_q;
    grant_r    = 1'b0;
    grant_b    = 1'b0;
    b_ready    = 1'b0;
    r_ready    = 1'b0;
    link_valid = 1'b0;
    head       = 1'b0;
    tail       = 1'b0;
    payload    = '0;

    case (state_q)
      IDLE: begin
        // prio_r_q set means B won last time (or fresh reset), so R wins a tie
        grant_r = r_valid && (prio_r_q || !b_valid);
        grant_b = b_valid && !grant_r;
        r_ready = grant_r;
        b_ready = grant_b;
        if (grant_r) begin
          r_node_d = r_node_id;
          r_tid_d  = r_tid;
          r_resp_d = r_resp;
          r_last_d = r_last;
          r_data_d = r_data;
          beat_d   = '0;
          prio_r_d = 1'b0;
          state_d  = SEND_RH;
        end else if (grant_b) begin
          b_node_d = b_node_id;
          b_tid_d  = b_tid;
          b_resp_d = b_resp;
          prio_r_d = 1'b1;
          state_d  = SEND_B;
        end
      end
      SEND_B: begin
        link_valid = 1'b1;
        head       = 1'b1;
        tail       = 1'b1;
        payload    = b_pl;
        if (link_ready) state_d = IDLE;
      end
      SEND_RH: begin
        link_valid = 1'b1;
        head       = 1'b1;
        payload    = r_pl;
        if (link_ready) state_d = SEND_RD;
      end
      SEND_RD: begin
        link_valid = 1'b1;
        tail       = (beat_q == LAST_BEAT);
        payload    = r_words[beat_q];
        if (link_ready) begin
          if (beat_q == LAST_BEAT) state_d = IDLE;
          else                     beat_d  = beat_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // handshakes must not leak out while reset is being applied
    if (!rstnn) begin
      b_ready    = 1'b0;
      r_ready    = 1'b0;
      link_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state_q  <= IDLE;
      prio_r_q <= 1'b1;
      beat_q   <= '0;
      b_node_q <= '0;
      b_tid_q  <= '0;
      b_resp_q <= '0;
      r_node_q <= '0;
      r_tid_q  <= '0;
      r_resp_q <= '0;
      r_last_q <= 1'b0;
      r_data_q <= '0;
    end else begin
      state_q  <= state_d;
      prio_r_q <= prio_r_d;
      beat_q   <= beat_d;
      b_node_q <= b_node_d;
      b_tid_q  <= b_tid_d;
      b_resp_q <= b_resp_d;
      r_node_q <= r_node_d;
      r_tid_q  <= r_tid_d;
      r_resp_q <= r_resp_d;
      r_last_q <= r_last_d;
      r_data_q <= r_data_d;
    end
  end

endmodule

// File: tb/tb_munoc_response_packetizer.sv
// Directed bench: stimulus tasks queue expected flits at input handshake,
// a negedge monitor pops and compares every accepted link flit.
module tb_munoc_response_packetizer;

  logic        clk = 1'b0;
  logic        rstnn;
  logic        b_valid, b_ready;
  logic [3:0]  b_node_id, b_tid;
  logic [1:0]  b_resp;
  logic        r_valid, r_ready;
  logic [3:0]  r_node_id, r_tid;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [63:0] r_data;
  logic        link_valid, link_ready;
  logic [33:0] link_flit;

  int total = 0;
  int bad   = 0;
  logic [33:0] exp_q[$];
  logic [7:0]  grant_log[$];

  always #5 clk = ~clk;

  munoc_response_packetizer #(.BW_DATA(64), .BW_TID(4), .BW_NODE_ID(4)) dut (
    .clk(clk), .rstnn(rstnn),
    .b_valid(b_valid), .b_ready(b_ready), .b_node_id(b_node_id), .b_tid(b_tid), .b_resp(b_resp),
    .r_valid(r_valid), .r_ready(r_ready), .r_node_id(r_node_id), .r_tid(r_tid), .r_resp(r_resp),
    .r_last(r_last), .r_data(r_data),
    .link_valid(link_valid), .link_ready(link_ready), .link_flit(link_flit)
  );

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [33:0] b_exp(input logic [3:0] n, input logic [3:0] t, input logic [1:0] rs);
    logic [31:0] p;
    p = '0;
    p[31:30] = 2'b01; p[29:26] = n; p[25:22] = t; p[21:20] = rs;
    return {2'b11, p};
  endfunction

  function automatic logic [33:0] rh_exp(input logic [3:0] n, input logic [3:0] t, input logic [1:0] rs,
                                         input logic l);
    logic [31:0] p;
    p = '0;
    p[31:30] = 2'b10; p[29:26] = n; p[25:22] = t; p[21:20] = rs; p[19] = l;
    return {2'b10, p};
  endfunction

  task automatic send_b(input logic [3:0] n, input logic [3:0] t, input logic [1:0] rs);
    int k;
    @(posedge clk); #1;
    b_valid = 1'b1; b_node_id = n; b_tid = t; b_resp = rs;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_ready) break;
    end
    if (k == 50) begin
      total++; bad++;
      $display("FAIL b_handshake: got timeout expected b_ready");
      b_valid = 1'b0;
      return;
    end
    exp_q.push_back(b_exp(n, t, rs));
    grant_log.push_back(8'h42);
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic send_r(input logic [3:0] n, input logic [3:0] t, input logic [1:0] rs,
                        input logic l, input logic [63:0] d);
    int k;
    @(posedge clk); #1;
    r_valid = 1'b1; r_node_id = n; r_tid = t; r_resp = rs; r_last = l; r_data = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (r_ready) break;
    end
    if (k == 50) begin
      total++; bad++;
      $display("FAIL r_handshake: got timeout expected r_ready");
      r_valid = 1'b0;
      return;
    end
    exp_q.push_back(rh_exp(n, t, rs, l));
    exp_q.push_back({2'b00, d[31:0]});
    exp_q.push_back({2'b01, d[63:32]});
    grant_log.push_back(8'h52);
    @(posedge clk); #1;
    r_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain", 34'(exp_q.size()), 34'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstnn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstnn = 1'b1;
    exp_q.delete();
  endtask

  // monitor: accepted flits vs scoreboard, stall stability, idle gap after tail
  logic [33:0] prev_flit = '0;
  logic        prev_stall = 1'b0;
  logic        prev_tail  = 1'b0;

  always @(negedge clk) begin
    if (rstnn) begin
      if (prev_stall && link_valid) check("stall_stable", link_flit, prev_flit);
      if (prev_tail) check("idle_gap", 34'(link_valid), 34'h0);
      if (link_valid && link_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_flit: got %h expected none", link_flit);
        end else begin
          check("flit", link_flit, exp_q.pop_front());
        end
      end
      prev_stall = link_valid && !link_ready;
      prev_flit  = link_flit;
      prev_tail  = link_valid && link_ready && link_flit[32];
    end else begin
      prev_stall = 1'b0;
      prev_tail  = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] pat = 16'b1011_0010_0110_1001;

  initial begin
    int k;
    rstnn = 1'b0; link_ready = 1'b1;
    b_valid = 1'b1; b_node_id = '0; b_tid = '0; b_resp = '0;
    r_valid = 1'b1; r_node_id = '0; r_tid = '0; r_resp = '0; r_last = 1'b0; r_data = '0;

    // reset: outputs held low even with valids pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_b_ready", 34'(b_ready), 34'h0);
    check("rst_r_ready", 34'(r_ready), 34'h0);
    check("rst_link_valid", 34'(link_valid), 34'h0);
    b_valid = 1'b0; r_valid = 1'b0;
    @(posedge clk); #1;
    rstnn = 1'b1;
    @(negedge clk);
    check("idle_link_valid", 34'(link_valid), 34'h0);

    // single B
    send_b(4'd3, 4'd5, 2'd2);
    check("b_latency", 34'(link_valid), 34'h1);
    check("b_flit_hand", link_flit, 34'h3_4D60_0000);
    drain();

    // single R, LS word first
    send_r(4'd1, 4'd2, 2'd0, 1'b1, 64'h1122334455667788);
    check("r_hdr_hand", link_flit, 34'h2_8488_0000);
    @(posedge clk); #1;
    check("r_beat0_hand", link_flit, 34'h0_5566_7788);
    @(posedge clk); #1;
    check("r_beat1_hand", link_flit, 34'h1_1122_3344);
    drain();

    // simultaneous valids after reset: R, B, R
    do_reset();
    grant_log.delete();
    fork
      begin
        send_r(4'd2, 4'd1, 2'd1, 1'b1, 64'hA5A5A5A5_5A5A5A5A);
        send_r(4'd6, 4'd7, 2'd3, 1'b0, 64'h0F0F0F0F_F0F0F0F0);
      end
      send_b(4'd4, 4'd3, 2'd0);
    join
    drain();
    check("grant_cnt", 34'(grant_log.size()), 34'd3);
    if (grant_log.size() == 3) begin
      check("grant0", 34'(grant_log[0]), 34'h52);
      check("grant1", 34'(grant_log[1]), 34'h42);
      check("grant2", 34'(grant_log[2]), 34'h52);
    end

    // link_ready toggling during R packets
    fork
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        link_ready = pat[i % 16];
      end
      begin
        send_r(4'd9, 4'd8, 2'd2, 1'b1, 64'hCAFEBABE_DEADBEEF);
        send_r(4'd3, 4'd3, 2'd1, 1'b0, 64'h01020304_05060708);
      end
    join
    @(posedge clk); #1;
    link_ready = 1'b1;
    drain();

    // reset during SEND_RD beat 1 aborts the packet
    send_r(4'd5, 4'd6, 2'd2, 1'b1, 64'hDEADBEEF_CAFEF00D);
    for (k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (link_valid && link_flit[33:32] == 2'b01) break;
    end
    check("found_beat1", 34'(k < 20), 34'h1);
    rstnn = 1'b0; link_ready = 1'b0;
    #1;
    check("rst_comb_valid", 34'(link_valid), 34'h0);
    @(posedge clk); #1;
    rstnn = 1'b1;
    exp_q.delete();
    check("rst_next_valid", 34'(link_valid), 34'h0);
    link_ready = 1'b1;
    send_b(4'hA, 4'h9, 2'b11);
    check("post_rst_b", link_flit, 34'h3_6A70_0000);
    drain();

    // R arriving while B is stalled on the link
    link_ready = 1'b0;
    send_b(4'd1, 4'd1, 2'd1);
    @(posedge clk); #1;
    r_valid = 1'b1; r_node_id = 4'd7; r_tid = 4'd3; r_resp = 2'd0; r_last = 1'b0;
    r_data = 64'h01234567_89ABCDEF;
    repeat (3) begin
      @(negedge clk);
      check("r_ready_blocked", 34'(r_ready), 34'h0);
    end
    @(posedge clk); #1;
    link_ready = 1'b1;
    send_r(4'd7, 4'd3, 2'd0, 1'b0, 64'h01234567_89ABCDEF);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/munoc_response_packetizer.md
MUNOC_RESPONSE_PACKETIZER -- requirements
Module: munoc_response_packetizer

Interface
REQ-001 SHALL have parameter BW_DATA, default 64, meaning read-data width; legal values are multiples of 32, from 32 to 256.
REQ-002 SHALL have parameter BW_TID, default 4, meaning AXI transaction ID width.
REQ-003 SHALL have parameter BW_NODE_ID, default 4, meaning destination master node ID width; BW_NODE_ID+BW_TID SHALL be at most 25.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rstnn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports b_valid (in, 1), b_ready (out, 1), b_node_id (in, BW_NODE_ID), b_tid (in, BW_TID), b_resp (in, 2): the write-response input channel.
REQ-007 SHALL have ports r_valid (in, 1), r_ready (out, 1), r_node_id (in, BW_NODE_ID), r_tid (in, BW_TID), r_resp (in, 2), r_last (in, 1), r_data (in, BW_DATA): the read-response input channel.
REQ-008 SHALL have ports link_valid (out, 1), link_ready (in, 1), link_flit (out, 34) = {head, tail, payload[31:0]}: the outgoing NoC link.

Function
REQ-009 SHALL use FSM states IDLE, SEND_B, SEND_RH, SEND_RD; the reset state is IDLE.
REQ-010 In IDLE only: b_ready and r_ready SHALL be asserted according to grant; in every other state both SHALL be 0.
REQ-011 SHALL arbitrate round-robin in IDLE: if only one valid is pending, that channel is granted. If both are pending, the channel not granted last time wins. After reset, R has priority.
REQ-012 SHALL drive ready combinationally only for the granted channel, and only while that channel's valid is high.
REQ-013 On a B handshake, SHALL capture the B fields into registers and enter SEND_B in the next cycle.
REQ-014 On an R handshake, SHALL capture the R fields and r_data into registers, clear the beat counter to 0, and enter SEND_RH.
REQ-015 SHALL hold link_valid = 1 in SEND_B, SEND_RH and SEND_RD, and 0 in IDLE.
REQ-016 Whenever link_valid=1 and link_ready=0, link_flit SHALL remain stable.
REQ-017 SEND_B flit: head=1, tail=1, payload = {2'b01, b_node_id, b_tid, b_resp, zero-fill} with the fields MSB-aligned. On link_ready the FSM SHALL go to IDLE.
REQ-018 SEND_RH flit: head=1, tail=0, payload = {2'b10, r_node_id, r_tid, r_resp, r_last, zero-fill} with the fields MSB-aligned. On link_ready the FSM SHALL go to SEND_RD.
REQ-019 SEND_RD flit k (k = 0 .. BW_DATA/32-1): head=0, payload = r_data[32k+31:32k], so the least-significant word is sent first. tail=1 only on the final flit.
REQ-020 In SEND_RD the beat counter SHALL increment on each link_ready. After the final flit is accepted, the FSM SHALL go to IDLE.
REQ-021 Packets SHALL never interleave; once a packet starts, it runs to tail regardless of new valids.
REQ-022 Minimum latency SHALL be: input handshake in cycle N gives the first flit valid in cycle N+1. A B packet therefore occupies 1 link cycle, and an R packet occupies 1+BW_DATA/32 link cycles.
REQ-023 Back-to-back throughput SHALL include one IDLE cycle between packets; the IDLE cycle is required.
REQ-024 Payload type encodings 2'b00 and 2'b11 SHALL never be emitted.

Reset
REQ-025 When rstnn=0 at a rising clk edge, the block SHALL set: state=IDLE, beat counter=0, round-robin pointer=R-priority, all capture registers=0.
REQ-026 During and immediately after reset, link_valid, b_ready and r_ready SHALL be 0 combinationally while rstnn=0.
REQ-027 Reset in the middle of a packet SHALL abort that packet with no tail flit; the first flit after reset SHALL be a head flit.

Verification
REQ-028 Single B: b_node_id=3, b_tid=5, b_resp=2, link_ready=1 -> exactly one flit the next cycle, with head=1, tail=1, payload[31:30]=01 and fields 3/5/2 in order.
REQ-029 Single R, BW_DATA=64, r_data=0x1122334455667788, link_ready=1 -> three consecutive flits: header, then 0x55667788, then 0x11223344 with tail=1.
REQ-030 B and R valid simultaneously after reset, both held valid -> R packet first, B packet next, then R again; grants alternate.
REQ-031 link_ready toggled 0/1 pseudo-randomly during an R packet -> no flit is lost or duplicated, and link_flit is stable while stalled.
REQ-032 rstnn driven low during SEND_RD beat 1 -> link_valid=0 on the next cycle. A fresh B then yields a head=1, tail=1 flit with no residual data.
REQ-033 r_valid arriving while in SEND_B -> r_ready stays 0 until IDLE, and r_data is captured unchanged.
